// File: rtl/ft_in_packet_parser_pkg.sv
// Shared constants for the FTDI host-packet parser: ID byte default, header length, FSM encodings.
// Latency: none (declarations only). Backpressure: not applicable.
package ft_host_pkg;
  localparam logic [7:0] ID_BYTE_DEFAULT = 8'hCD;
  localparam int         HDR_LEN         = 9;

  // Parser states
  localparam logic [2:0] HDR_ID    = 3'd0;
  localparam logic [2:0] HDR_COUNT = 3'd1;
  localparam logic [2:0] HDR_CMD   = 3'd2;
  localparam logic [2:0] HDR_ADDR  = 3'd3;
  localparam logic [2:0] DATA      = 3'd4;
  localparam logic [2:0] ISSUE     = 3'd5;

  // Fetcher states
  localparam logic [0:0] FETCH_IDLE   = 1'b0;
  localparam logic [0:0] FETCH_ACTIVE = 1'b1;
endpackage

// File: rtl/ft_in_packet_parser_byte_fetcher.sv
// Pops bytes from one incoming FTDI FIFO buffer at a time, one read outstanding.
// Latency: byte valid the cycle after the read strobe; one byte per 2 cycles.
// Backpressure: stall holds off new reads; an outstanding byte is still delivered.
module ft_byte_fetcher
  import ft_host_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_fifo_ready,
  output logic        in_fifo_activate,
  input  logic [23:0] in_fifo_count,
  output logic        in_fifo_read,
  input  logic [7:0]  in_fifo_data,
  input  logic        start_of_frame,
  input  logic        stall,
  output logic        byte_vld,
  output logic [7:0]  byte_dat,
  output logic        byte_sof
);
  logic [0:0]  fstate;
  logic [23:0] bytes_left;

  assign in_fifo_activate = (fstate == FETCH_ACTIVE);
  assign byte_dat         = in_fifo_data;
  assign byte_sof         = start_of_frame;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fstate       <= FETCH_IDLE;
      bytes_left   <= '0;
      in_fifo_read <= 1'b0;
      byte_vld     <= 1'b0;
    end else begin
      byte_vld     <= in_fifo_read;
      in_fifo_read <= 1'b0;
      case (fstate)
        FETCH_IDLE: begin
          if (in_fifo_ready) begin
            fstate     <= FETCH_ACTIVE;
            bytes_left <= in_fifo_count;
          end
        end
        default: begin
          // A read issued last cycle is still in flight until its byte lands.
          if (!in_fifo_read) begin
            if (bytes_left != 24'd0) begin
              if (!stall) begin
                in_fifo_read <= 1'b1;
                bytes_left   <= bytes_left - 24'd1;
              end
            end else begin
              fstate <= FETCH_IDLE;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/ft_in_packet_parser.sv
// Frames host bytes into header + 32-bit word transactions (optional SOF resync: FT_IN_PARSER_SOF_RESYNC_EN).
// Latency: first o_en 28 cycles after in_fifo_ready for a one-word packet; next words >= 8 cycles apart.
// Backpressure: o_en holds all fields until i_master_ready; byte fetching stalls meanwhile.
module ft_in_packet_parser
  import ft_host_pkg::*;
#(
  parameter logic [7:0] ID_BYTE       = ID_BYTE_DEFAULT,
  parameter int         ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_fifo_ready,
  output logic                     in_fifo_activate,
  input  logic [23:0]              in_fifo_count,
  output logic                     in_fifo_read,
  input  logic [7:0]               in_fifo_data,
  input  logic                     start_of_frame,
  output logic                     o_en,
  input  logic                     i_master_ready,
  output logic [7:0]               o_command,
  output logic [31:0]              o_address,
  output logic [31:0]              o_data,
  output logic [23:0]              o_data_count,
  output logic                     o_frame_error,
  output logic [ERR_CNT_WIDTH-1:0] o_error_count
);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = 1;

  logic       byte_vld;
  logic [7:0] byte_dat;
  logic       byte_sof;
  logic       stall;
  logic       resync;
  logic [2:0] st;
  logic [1:0] idx;

  ft_byte_fetcher u_fetch (
    .clk              (clk),
    .rst              (rst),
    .in_fifo_ready    (in_fifo_ready),
    .in_fifo_activate (in_fifo_activate),
    .in_fifo_count    (in_fifo_count),
    .in_fifo_read     (in_fifo_read),
    .in_fifo_data     (in_fifo_data),
    .start_of_frame   (start_of_frame),
    .stall            (stall),
    .byte_vld         (byte_vld),
    .byte_dat         (byte_dat),
    .byte_sof         (byte_sof)
  );

`ifdef FT_IN_PARSER_SOF_RESYNC_EN
  assign resync = byte_vld & byte_sof;
`else
  assign resync = 1'b0;
  wire unused_sof = byte_sof;
`endif

  // Also stall on the byte that completes a word, so no read lands while o_en is up.
  assign stall = o_en | (byte_vld & (idx == 2'd3) & ((st == DATA) | (st == HDR_ADDR)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st            <= HDR_ID;
      idx           <= 2'd0;
      o_en          <= 1'b0;
      o_command     <= '0;
      o_address     <= '0;
      o_data        <= '0;
      o_data_count  <= '0;
      o_frame_error <= 1'b0;
      o_error_count <= '0;
    end else begin
      o_frame_error <= 1'b0;
      if (byte_vld && (resync || st == HDR_ID)) begin
        // An abort and a bad ID on the same byte merge into one pulse.
        if ((resync && st != HDR_ID) || byte_dat != ID_BYTE) begin
          o_frame_error <= 1'b1;
          if (~&o_error_count) o_error_count <= o_error_count + ERR_ONE;
        end
        idx <= 2'd0;
        st  <= (byte_dat == ID_BYTE) ? HDR_COUNT : HDR_ID;
      end else if (byte_vld) begin
        case (st)
          HDR_COUNT: begin
            o_data_count <= {o_data_count[15:0], byte_dat};
            idx          <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            if (idx == 2'd2) st <= HDR_CMD;
          end
          HDR_CMD: begin
            o_command <= byte_dat;
            st        <= HDR_ADDR;
          end
          HDR_ADDR: begin
            o_address <= {o_address[23:0], byte_dat};
            idx       <= idx + 2'd1;
            if (idx == 2'd3) begin
              if (o_data_count == 24'd0) begin
                o_data <= '0;
                o_en   <= 1'b1;
                st     <= ISSUE;
              end else begin
                st <= DATA;
              end
            end
          end
          DATA: begin
            o_data <= {o_data[23:0], byte_dat};
            idx    <= idx + 2'd1;
            if (idx == 2'd3) begin
              o_en <= 1'b1;
              st   <= ISSUE;
            end
          end
          default: ;
        endcase
      end else if (st == ISSUE && i_master_ready) begin
        o_en <= 1'b0;
        if (o_data_count > 24'd1) begin
          o_data_count <= o_data_count - 24'd1;
          st           <= DATA;
        end else begin
          st <= HDR_ID;
        end
      end
    end
  end
endmodule

// File: tb/tb_ft_in_packet_parser.sv
// Scoreboard bench: a byte-stream reference parser predicts transactions and error pulses.
module tb_ft_in_packet_parser;
  typedef struct packed {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [23:0] cnt;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_fifo_ready = 1'b0;
  logic        in_fifo_activate;
  logic [23:0] in_fifo_count = '0;
  logic        in_fifo_read;
  logic [7:0]  in_fifo_data = '0;
  logic        start_of_frame = 1'b0;
  logic        o_en;
  logic        i_master_ready = 1'b0;
  logic [7:0]  o_command;
  logic [31:0] o_address;
  logic [31:0] o_data;
  logic [23:0] o_data_count;
  logic        o_frame_error;
  logic [15:0] o_error_count;

  always #5 clk = ~clk;

  ft_in_packet_parser #(.ID_BYTE(8'hCD), .ERR_CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_fifo_ready(in_fifo_ready), .in_fifo_activate(in_fifo_activate),
    .in_fifo_count(in_fifo_count), .in_fifo_read(in_fifo_read), .in_fifo_data(in_fifo_data),
    .start_of_frame(start_of_frame), .o_en(o_en), .i_master_ready(i_master_ready),
    .o_command(o_command), .o_address(o_address), .o_data(o_data), .o_data_count(o_data_count),
    .o_frame_error(o_frame_error), .o_error_count(o_error_count)
  );

  int n_cmp = 0, n_err = 0;
  logic [7:0] stg_b[$];
  bit         stg_s[$];
  int         stg_len[$];
  int         stg_mark = 0;
  logic [7:0] feed_b[$];
  bit         feed_s[$];
  int         buf_len[$];
  int         remaining = 0;
  bit         act_seen = 0, act_prev = 0;
  txn_t       exp_q[$];
  int         err_seen = 0, act_cnt = 0, exp_err_total = 0;
  int         ready_mode = 0, hold_cnt = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Host side of the ping-pong FIFO: offers queued buffers and serves reads.
  always @(negedge clk) begin
    if (in_fifo_activate) begin
      if (!act_seen) begin
        act_seen      = 1;
        in_fifo_ready = 1'b0;
      end
      if (in_fifo_read) begin
        check("read_in_buffer", remaining > 0, 1);
        if (remaining > 0 && feed_b.size() > 0) begin
          in_fifo_data   = feed_b.pop_front();
          start_of_frame = feed_s.pop_front();
          remaining--;
        end
      end
    end else begin
      if (act_seen) begin
        act_seen = 0;
        check("buffer_drained", remaining, 0);
        remaining = 0;
      end
      if (!in_fifo_ready && buf_len.size() > 0) begin
        remaining     = buf_len.pop_front();
        in_fifo_count = 24'(remaining);
        in_fifo_ready = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: i_master_ready = 1'b1;
      1: i_master_ready = 1'($urandom_range(0, 1));
      default: begin
        if (o_en) begin
          hold_cnt++;
          i_master_ready = (hold_cnt > 10);
        end else begin
          hold_cnt       = 0;
          i_master_ready = 1'b0;
        end
      end
    endcase
  end

  // Monitor: every cycle o_en is up the fields must equal the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_frame_error) err_seen++;
      if (in_fifo_activate && !act_prev) act_cnt++;
      act_prev = in_fifo_activate;
      if (o_en) begin
        check("rd_during_en", in_fifo_read, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_txn", o_en, 0);
        end else begin
          check("txn", {o_command, o_address, o_data, o_data_count}, exp_q[0]);
          if (i_master_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  function automatic int scan(input int start, input int len, output int q);
    q = -1;
    for (int i = start; i < start + len; i++) begin
      if (i >= stg_b.size()) return 1;
`ifdef FT_IN_PARSER_SOF_RESYNC_EN
      if (stg_s[i]) begin
        q = i;
        return 2;
      end
`endif
    end
    return 0;
  endfunction

  // Reference: walk the staged byte stream packet by packet.
  task automatic model_stream(output int errs);
    int p, r, q, n;
    logic [23:0] cnt;
    logic [7:0]  cmd;
    logic [31:0] addr, w;
    bit stop;
    errs = 0; p = 0; n = stg_b.size(); stop = 0;
    while (p < n && !stop) begin
      if (stg_b[p] != 8'hCD) begin
        errs++;
        p++;
      end else begin
        r = scan(p + 1, 8, q);
        if (r == 1) stop = 1;
        else if (r == 2) begin
          errs++;
          p = (stg_b[q] == 8'hCD) ? q : q + 1;
        end else begin
          cnt  = {stg_b[p+1], stg_b[p+2], stg_b[p+3]};
          cmd  = stg_b[p+4];
          addr = {stg_b[p+5], stg_b[p+6], stg_b[p+7], stg_b[p+8]};
          p += 9;
          if (cnt == 0) exp_q.push_back(txn_t'{cmd, addr, 32'h0, 24'h0});
          for (int k = 0; k < int'(cnt); k++) begin
            r = scan(p, 4, q);
            if (r == 1) begin stop = 1; break; end
            if (r == 2) begin
              errs++;
              p = (stg_b[q] == 8'hCD) ? q : q + 1;
              break;
            end
            w = {stg_b[p], stg_b[p+1], stg_b[p+2], stg_b[p+3]};
            exp_q.push_back(txn_t'{cmd, addr, w, cnt - 24'(k)});
            p += 4;
          end
        end
      end
    end
  endtask

  task automatic add_byte(input logic [7:0] b, input bit s);
    stg_b.push_back(b);
    stg_s.push_back(s);
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) add_byte(w[i*8 +: 8], 0);
  endtask

  task automatic add_hdr(input logic [23:0] cnt, input logic [7:0] cmd, input logic [31:0] addr);
    add_byte(8'hCD, 1);
    add_byte(cnt[23:16], 0); add_byte(cnt[15:8], 0); add_byte(cnt[7:0], 0);
    add_byte(cmd, 0);
    add_word(addr);
  endtask

  task automatic cut();
    stg_len.push_back(stg_b.size() - stg_mark);
    stg_mark = stg_b.size();
  endtask

  task automatic run_test(input string name);
    int errs, e0, a0, nacts;
    bit idle;
    model_stream(errs);
    nacts = stg_len.size();
    e0 = err_seen; a0 = act_cnt;
    foreach (stg_b[i]) begin
      feed_b.push_back(stg_b[i]);
      feed_s.push_back(stg_s[i]);
    end
    foreach (stg_len[i]) buf_len.push_back(stg_len[i]);
    stg_b.delete(); stg_s.delete(); stg_len.delete(); stg_mark = 0;
    idle = 0;
    for (int c = 0; c < 20000 && !idle; c++) begin
      @(negedge clk);
      idle = (buf_len.size() == 0) && (remaining == 0) && !in_fifo_ready &&
             !in_fifo_activate && (exp_q.size() == 0);
    end
    check({name, "_done"}, idle, 1);
    if (!idle) exp_q.delete();
    repeat (4) @(negedge clk);
    exp_err_total += errs;
    check({name, "_err_pulses"}, err_seen - e0, errs);
    check({name, "_activations"}, act_cnt - a0, nacts);
    check({name, "_err_count"}, o_error_count, exp_err_total);
  endtask

  initial begin
    logic [7:0] j;
    int npk, cnt, rem, n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {o_en, o_command, o_address, o_data, o_data_count, o_frame_error,
                            o_error_count, in_fifo_activate, in_fifo_read}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_outputs", {o_en, o_command, o_address, o_data, o_data_count, o_frame_error,
                                 o_error_count, in_fifo_activate, in_fifo_read}, 0);

    ready_mode = 0;
    add_hdr(24'd1, 8'h01, 32'h0000_1000); add_word(32'hDEAD_BEEF); cut();
    run_test("single_word");

    ready_mode = 2;
    add_hdr(24'd3, 8'h03, 32'h0000_2000);
    add_word(32'h1111_2222); add_word(32'h3333_4444); add_word(32'h5555_6666); cut();
    run_test("backpressure");

    ready_mode = 0;
    add_hdr(24'd0, 8'h02, 32'h0000_0004); cut();
    run_test("zero_count");

    add_byte(8'h55, 0);
    add_hdr(24'd1, 8'h07, 32'hA5A5_0000); add_word(32'h0BAD_F00D); cut();
    run_test("bad_id");

    add_hdr(24'd1, 8'h01, 32'h0000_1000); add_word(32'hCAFE_0001);
    stg_len.push_back(5); stg_len.push_back(8); stg_mark = 13;
    run_test("split");

    cut();
    add_hdr(24'd2, 8'h09, 32'h0000_0040); add_word(32'h0000_00CD); add_word(32'hCDCD_CDCD); cut();
    run_test("empty_buffer");

    add_byte(8'hCD, 1); add_byte(8'h00, 0); add_byte(8'h00, 0); add_byte(8'h01, 0);
    add_hdr(24'd1, 8'h01, 32'h0000_1000); add_word(32'hDEAD_BEEF); cut();
    run_test("resync");

    ready_mode = 1;
    for (int t = 0; t < 25; t++) begin
      npk = $urandom_range(1, 3);
      for (int k = 0; k < npk; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          j = 8'($urandom_range(0, 255));
          if (j == 8'hCD) j = 8'h00;
          add_byte(j, 0);
        end
        cnt = $urandom_range(0, 3);
        add_hdr(24'(cnt), 8'($urandom_range(0, 255)), $urandom);
        for (int w = 0; w < cnt; w++) add_word($urandom);
      end
      rem = stg_b.size();
      while (rem > 0) begin
        n = $urandom_range(0, 16);
        if (n > rem) n = rem;
        stg_len.push_back(n);
        rem -= n;
      end
      run_test("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ft_in_packet_parser.md
# ft_in_packet_parser

Downstream consumer of the FTDI FIFO interface's incoming (host-to-FPGA) ping-pong FIFO. It activates a FIFO buffer, pops bytes, and frames them into host command packets of header plus 32-bit data words. It presents one transaction per data word to the wishbone master with a valid/ready handshake. Runs entirely in the `clk` domain, on the read side of the incoming FIFO.

## Interface
Parameters:
- `ID_BYTE`, 8'hCD, required first byte of every packet.
- `ERR_CNT_WIDTH`, 16, width of the saturating error counter.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: async active-high reset.
- `in_fifo_ready` in 1: a FIFO buffer is available to read.
- `in_fifo_activate` out 1: holds the buffer while reading.
- `in_fifo_count` in 24: bytes in the offered buffer; sampled at activation.
- `in_fifo_read` out 1: one-cycle pop strobe.
- `in_fifo_data` in 8: popped byte, valid the cycle after `in_fifo_read`.
- `start_of_frame` in 1: travels with `in_fifo_data`; marks the first byte of a USB frame.
- `o_en` out 1: transaction valid.
- `i_master_ready` in 1: master accepts the transaction when `o_en` is also high.
- `o_command` out 8, `o_address` out 32, `o_data` out 32.
- `o_data_count` out 24: words remaining, including the current one.
- `o_frame_error` out 1: one-cycle pulse on a bad ID or an aborted packet.
- `o_error_count` out `ERR_CNT_WIDTH`: saturating count of `o_frame_error` pulses.

## Operation
- Packet layout, big-endian: `ID_BYTE`, data_count[23:0] (3 bytes), command[7:0], address[31:0], then data_count × 32-bit words. Header is 9 bytes.
- Fetcher:
  - If `in_fifo_activate`=0 and `in_fifo_ready`=1: next cycle set activate=1 and latch `in_fifo_count` into `bytes_left`.
  - With activate=1, `bytes_left`>0 and `o_en`=0: pulse `in_fifo_read`, decrement `bytes_left`, capture byte and SOF the next cycle.
  - One read outstanding at a time.
  - When `bytes_left`=0 and no read is outstanding: drop activate next cycle.
  - Parser state is preserved, so packets may span FIFO buffers.
- Parser states:
  - HDR_ID: a byte ≠ `ID_BYTE` is dropped and pulses `o_frame_error`; stay in HDR_ID.
  - HDR_COUNT (3 bytes) → HDR_CMD (1 byte) → HDR_ADDR (4 bytes) → DATA (4 bytes) → ISSUE.
  - A 2-bit byte index is shared by all multi-byte states.
- ISSUE:
  - `o_en`=1, holding command, address, data and `o_data_count` stable until `o_en & i_master_ready`.
  - `o_en` falls the cycle after acceptance.
  - Then: if `o_data_count` was 1 → HDR_ID, else → DATA with count−1.
  - `o_address` is constant for the whole packet; the master increments.
- data_count = 0 (read/control command): after HDR_ADDR go directly to ISSUE once, with `o_data`=0 and `o_data_count`=0, then HDR_ID.
- Error counter increments on each `o_frame_error` and holds at all-ones.

## Timing
- Reset values: every output is 0, including `in_fifo_activate` and `in_fifo_read`. Parser goes to HDR_ID.
- Reset is asynchronous; asserting it mid-packet abandons the packet with no error pulse.
- Throughput: 2 cycles per byte.
- Latency: first `o_en` ≥ 2 + 2×13 = 28 cycles after `in_fifo_ready` rises, for a packet with one data word.
- Further words arrive ≥ 8 cycles after the previous acceptance.
- The fetcher stalls while `o_en`=1, so it never has more than one word in flight.
- `in_fifo_count`=0 at activation: release the buffer the following cycle with no reads.
- A byte capture and a handshake in the same cycle are impossible by construction (the fetcher is stalled).

## Configuration
- `FT_IN_PARSER_SOF_RESYNC_EN` defined:
  - A captured byte with `start_of_frame`=1 is always treated as an HDR_ID byte.
  - If the parser was not in HDR_ID and not in ISSUE, it first pulses `o_frame_error` (abort).
  - An SOF arriving during ISSUE waits until acceptance.
- Undefined: `start_of_frame` is ignored; framing relies only on the header.

## Structure
- Package `ft_host_pkg` holds:
  - `ID_BYTE` default and header length (9).
  - Parser state enum (HDR_ID, HDR_COUNT, HDR_CMD, HDR_ADDR, DATA, ISSUE).
  - Fetcher state enum.
- One sub-module, `ft_byte_fetcher`: owns the activate/read/count logic and emits byte, SOF and byte-valid, with a stall input.
- The parser FSM and output registers stay in the top level.

## Test plan
- Single-word write:
  - Stimulus: one 13-byte buffer `CD 00 00 01 01 00 00 10 00 DE AD BE EF`, `i_master_ready`=1.
  - Response: one `o_en` with cmd=01, addr=0x00001000, data=0xDEADBEEF, count=1; activate then drops.
- Backpressure:
  - Stimulus: 3-word packet, `i_master_ready` held low 10 cycles per word.
  - Response: outputs stable while stalled; counts 3,2,1; no reads during `o_en`.
- Zero-count read:
  - Stimulus: `CD 00 00 00 02 00 00 00 04`.
  - Response: one `o_en` with cmd=02, addr=4, data=0, count=0.
- Bad ID:
  - Stimulus: leading byte 0x55, then a valid packet.
  - Response: one `o_frame_error` pulse, error_count=1; the packet is still issued correctly.
- Packet split across buffers:
  - Stimulus: buffer of 5 bytes plus buffer of 8 bytes (one packet).
  - Response: two activations, one correct transaction.
- Resync (macro defined):
  - Stimulus: SOF on a 0xCD byte after 4 header bytes.
  - Response: abort pulse, new packet parsed.
  - Macro undefined: the same stimulus yields a misframed packet and no abort pulse.
